// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter (with alu_core)
// Purpose  : two-requester round-robin front end sharing one ALU and one
//            registered result slot with valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================

module alu_core (
    input  logic [3:0]  opcode_i,
    input  logic [31:0] in_1_i,
    input  logic [31:0] in_2_i,
    output logic [31:0] out_o,
    output logic        zero_o,
    output logic        err_o
);

    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_SUB  = 4'b0010;
    localparam logic [3:0] c_OP_XOR  = 4'b0011;
    localparam logic [3:0] c_OP_OR   = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_SLL  = 4'b0110;
    localparam logic [3:0] c_OP_SRL  = 4'b0111;
    localparam logic [3:0] c_OP_SRA  = 4'b1000;
    localparam logic [3:0] c_OP_SLT  = 4'b1001;
    localparam logic [3:0] c_OP_SLTU = 4'b1010;

    logic [4:0]  w_shamt;
    logic [31:0] w_out;
    logic        w_err;

    assign w_shamt = in_2_i[4:0];

    always_comb begin
        w_out = '0;
        w_err = 1'b0;
        case (opcode_i)
            c_OP_ADD:  w_out = in_1_i + in_2_i;
            c_OP_SUB:  w_out = in_1_i - in_2_i;
            c_OP_XOR:  w_out = in_1_i ^ in_2_i;
            c_OP_OR:   w_out = in_1_i | in_2_i;
            c_OP_AND:  w_out = in_1_i & in_2_i;
            c_OP_SLL:  w_out = in_1_i << w_shamt;
            c_OP_SRL:  w_out = in_1_i >> w_shamt;
            c_OP_SRA:  w_out = 32'($signed(in_1_i) >>> w_shamt);
            c_OP_SLT:  w_out = {31'd0, ($signed(in_1_i) < $signed(in_2_i))};
            c_OP_SLTU: w_out = {31'd0, (in_1_i < in_2_i)};
            // Unknown opcodes produce zero and flag the error.
            default:   w_err = 1'b1;
        endcase
    end

    assign out_o  = w_out;
    assign zero_o = (w_out == 32'd0);
    assign err_o  = w_err;

endmodule

module alu_arbiter #(
    parameter int RR_INIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_in_1,
    input  logic [31:0] req0_in_2,
    input  logic [3:0]  req0_opcode,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_in_1,
    input  logic [31:0] req1_in_2,
    input  logic [3:0]  req1_opcode,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_out,
    output logic        rsp0_zero,
    output logic        rsp0_err,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_out,
    output logic        rsp1_zero,
    output logic        rsp1_err
);

    localparam logic c_PRIO_INIT = (RR_INIT != 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t      state_q;
    logic        owner_q;
    logic        prio_q;
    logic [31:0] res_out_q;
    logic        res_zero_q;
    logic        res_err_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;

    logic        w_consume;
    logic        w_can_accept;
    logic        w_grant;
    logic        w_accept;
    logic [3:0]  w_opcode;
    logic [31:0] w_in_1;
    logic [31:0] w_in_2;
    logic [31:0] w_alu_out;
    logic        w_alu_zero;
    logic        w_alu_err;

    // The slot frees up in the same cycle its owner takes the result,
    // which is what allows back-to-back acceptance.
    assign w_consume    = (state_q == S_HOLD) &&
                          (owner_q ? rsp1_ready : rsp0_ready);
    assign w_can_accept = rst_n && ((state_q == S_IDLE) || w_consume);

    always_comb begin
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = prio_q;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept   = w_can_accept && (req0_valid || req1_valid);
    assign req0_ready = w_accept && !w_grant;
    assign req1_ready = w_accept &&  w_grant;

    assign w_opcode = w_grant ? req1_opcode : req0_opcode;
    assign w_in_1   = w_grant ? req1_in_1   : req0_in_1;
    assign w_in_2   = w_grant ? req1_in_2   : req0_in_2;

    alu_core u_alu (
        .opcode_i (w_opcode),
        .in_1_i   (w_in_1),
        .in_2_i   (w_in_2),
        .out_o    (w_alu_out),
        .zero_o   (w_alu_zero),
        .err_o    (w_alu_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            prio_q       <= c_PRIO_INIT;
            res_out_q    <= '0;
            res_zero_q   <= 1'b0;
            res_err_q    <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (w_accept) begin
                        state_q      <= S_HOLD;
                        owner_q      <= w_grant;
                        prio_q       <= !w_grant;
                        res_out_q    <= w_alu_out;
                        res_zero_q   <= w_alu_zero;
                        res_err_q    <= w_alu_err;
                        rsp0_valid_q <= !w_grant;
                        rsp1_valid_q <=  w_grant;
                    end else if (w_consume) begin
                        state_q      <= S_IDLE;
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_out   = res_out_q;
    assign rsp1_out   = res_out_q;
    assign rsp0_zero  = res_zero_q;
    assign rsp1_zero  = res_zero_q;
    assign rsp0_err   = res_err_q;
    assign rsp1_err   = res_err_q;

endmodule

`default_nettype wire
